// File: rtl/timer_pkg.sv
// Shared types for the timer APB slave: FSM states, register word map, address bound.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [9:0] {
    REG_CTRL     = 10'd0,
    REG_STATUS   = 10'd1,
    REG_LOAD     = 10'd2,
    REG_COUNT    = 10'd3,
    REG_PRESCALE = 10'd4,
    REG_CMP0     = 10'd5,
    REG_CMP1     = 10'd6,
    REG_CAP0     = 10'd7,
    REG_CAP1     = 10'd8,
    REG_IRQ_EN   = 10'd9,
    REG_IRQ_STAT = 10'd10,
    REG_IRQ_CLR  = 10'd11
  } reg_off_e;

  // Highest decoded byte address is the last word of the register map.
  localparam logic [31:0] ADDR_LAST_DEF = {20'h0_0000, REG_IRQ_CLR, 2'b00};

  localparam int WAIT_W = 4;

endpackage

// File: rtl/timer_addr_chk.sv
// Combinational APB address legality: word-aligned and not beyond ADDR_LAST.
module timer_addr_chk
  import timer_pkg::*;
#(
  parameter logic [31:0] ADDR_LAST = ADDR_LAST_DEF
) (
  input  logic [31:0] paddr,
  output logic        err
);

  assign err = (paddr[1:0] != 2'b00) || (paddr > ADDR_LAST);

endmodule

// File: rtl/timer_apb_slave.sv
// APB slave front-end for the timer register file; pready lands 2+WAIT_STATES cycles after SETUP starts.
// Register strobes are one cycle wide and suppressed on errored or aborted transfers.
module timer_apb_slave
  import timer_pkg::*;
#(
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ADDR_LAST   = ADDR_LAST_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        tim_psel,
  input  logic        tim_penable,
  input  logic        tim_pwrite,
  input  logic [31:0] tim_paddr,
  input  logic [31:0] tim_pwdata,
  output logic [31:0] tim_prdata,
  output logic        tim_pready,
  output logic        tim_pslverr,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  output logic [9:0]  reg_addr,
  output logic [31:0] reg_wdata,
  input  logic [31:0] reg_rdata
);

  state_e              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic                addr_err;
  logic                wr_q;
  logic                err_q;
  logic                rd_pend;
  logic                setup_hit;

  timer_addr_chk #(
    .ADDR_LAST (ADDR_LAST)
  ) u_addr_chk (
    .paddr (tim_paddr),
    .err   (addr_err)
  );

  assign setup_hit = (state == ST_IDLE) && (state_nxt == ST_ACCESS);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (tim_psel && !tim_penable) begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!tim_psel) begin
          state_nxt = ST_IDLE;
        end else if (WAIT_STATES == 0) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = WAIT_W'(WAIT_STATES);
        end
      end
      ST_WAIT: begin
        // The count hits zero on the edge that leaves WAIT, so WAIT spans WAIT_STATES cycles.
        if (!tim_psel) begin
          state_nxt    = ST_IDLE;
          wait_cnt_nxt = '0;
        end else if (wait_cnt <= WAIT_W'(1)) begin
          state_nxt    = ST_DONE;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt - WAIT_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt    = ST_IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Strobes are gated by psel so an abort in the same cycle never leaks a register access.
  assign reg_rd_en = (state == ST_ACCESS) && tim_psel && !wr_q && !err_q;
  assign reg_wr_en = (state == ST_DONE) && wr_q && !err_q;
  assign reg_wdata = reg_wr_en ? tim_pwdata : '0;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      reg_addr    <= '0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      rd_pend     <= 1'b0;
      tim_prdata  <= '0;
      tim_pready  <= 1'b0;
      tim_pslverr <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      rd_pend  <= reg_rd_en;
      if (setup_hit) begin
        reg_addr <= tim_paddr[11:2];
        wr_q     <= tim_pwrite;
        err_q    <= addr_err;
      end
      tim_pready  <= (state_nxt == ST_DONE);
      tim_pslverr <= (state_nxt == ST_DONE) && err_q;
      // Register file answers one cycle after the read strobe; errored reads return zero.
      if (rd_pend) begin
        tim_prdata <= reg_rdata;
      end else if ((state_nxt == ST_DONE) && err_q && !wr_q) begin
        tim_prdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_timer_apb_slave.sv
// Three DUT lanes (WAIT_STATES 1, 0, 3) driven by directed and random APB traffic, checked by a scoreboard.
module tb_timer_apb_slave;

  localparam logic [31:0] LAST_ADDR = 32'h0000_002C;

  typedef struct {
    bit          err;
    bit          chk_dat;
    logic [31:0] dat;
    int          t0;
  } rsp_t;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  logic sys_clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_lane
    localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        wr_en, rd_en;
    logic [9:0]  raddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] mem [16];
    bit          done_l = 1'b0;

    rsp_t        rsp_q[$];
    wr_t         wr_q[$];
    logic [9:0]  rd_q[$];

    timer_apb_slave #(
      .WAIT_STATES (WS),
      .ADDR_LAST   (LAST_ADDR)
    ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (rst),
      .tim_psel    (psel),
      .tim_penable (penable),
      .tim_pwrite  (pwrite),
      .tim_paddr   (paddr),
      .tim_pwdata  (pwdata),
      .tim_prdata  (prdata),
      .tim_pready  (pready),
      .tim_pslverr (pslverr),
      .reg_wr_en   (wr_en),
      .reg_rd_en   (rd_en),
      .reg_addr    (raddr),
      .reg_wdata   (wdata),
      .reg_rdata   (rdata)
    );

    // Register file model: read data appears the cycle after the strobe.
    always @(posedge sys_clk) begin
      if (rd_en) rdata <= mem[raddr[3:0]];
    end

    // Monitor: pops expectations whenever the DUT presents a response or a strobe.
    always @(negedge sys_clk) begin
      if (!rst) begin
        if (pready) begin
          if (rsp_q.size() == 0) begin
            fail_evt($sformatf("lane%0d unexpected pready at cycle %0d", g, cyc));
          end else begin
            rsp_t r;
            r = rsp_q.pop_front();
            check($sformatf("lane%0d pslverr", g), {31'b0, pslverr}, {31'b0, r.err});
            check($sformatf("lane%0d latency", g), cyc - r.t0, 2 + WS);
            if (r.chk_dat) check($sformatf("lane%0d prdata", g), prdata, r.dat);
          end
        end else begin
          check($sformatf("lane%0d pslverr_idle", g), {31'b0, pslverr}, 32'd0);
        end
        if (wr_en) begin
          if (wr_q.size() == 0) begin
            fail_evt($sformatf("lane%0d unexpected reg_wr_en addr=%0d", g, raddr));
          end else begin
            wr_t w;
            w = wr_q.pop_front();
            check($sformatf("lane%0d wr_addr", g), {22'b0, raddr}, {22'b0, w.a});
            check($sformatf("lane%0d wr_data", g), wdata, w.d);
          end
        end
        if (rd_en) begin
          if (rd_q.size() == 0) begin
            fail_evt($sformatf("lane%0d unexpected reg_rd_en addr=%0d", g, raddr));
          end else begin
            logic [9:0] a;
            a = rd_q.pop_front();
            check($sformatf("lane%0d rd_addr", g), {22'b0, raddr}, {22'b0, a});
          end
        end
      end
    end

    task automatic chk_all_zero(input string tag);
      check($sformatf("lane%0d %s prdata", g, tag), prdata, 32'd0);
      check($sformatf("lane%0d %s pready", g, tag), {31'b0, pready}, 32'd0);
      check($sformatf("lane%0d %s pslverr", g, tag), {31'b0, pslverr}, 32'd0);
      check($sformatf("lane%0d %s wr_en", g, tag), {31'b0, wr_en}, 32'd0);
      check($sformatf("lane%0d %s rd_en", g, tag), {31'b0, rd_en}, 32'd0);
      check($sformatf("lane%0d %s reg_addr", g, tag), {22'b0, raddr}, 32'd0);
      check($sformatf("lane%0d %s reg_wdata", g, tag), wdata, 32'd0);
    endtask

    // Entered #1 after a rising edge; leaves #1 after the edge closing DONE, bus idle.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] dat);
      rsp_t r;
      int   n;
      r.err     = (addr[1:0] != 2'b00) || (addr > LAST_ADDR);
      r.t0      = cyc;
      r.chk_dat = !wr && (r.err || WS > 0);
      r.dat     = r.err ? 32'd0 : mem[addr[5:2]];
      rsp_q.push_back(r);
      if (!r.err) begin
        if (wr) wr_q.push_back('{a: addr[11:2], d: dat});
        else    rd_q.push_back(addr[11:2]);
      end
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = dat;
      @(posedge sys_clk); #1;
      penable = 1'b1;
      n = 0;
      do begin
        @(negedge sys_clk);
        n++;
      end while (!pready && n < 40);
      if (!pready) fail_evt($sformatf("lane%0d timeout waiting pready addr=0x%08h", g, addr));
      @(posedge sys_clk); #1;
      psel = 1'b0; penable = 1'b0;
    endtask

    // Starts a write and leaves it sitting in WAIT.
    task automatic start_to_wait(input logic [31:0] addr);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = $urandom;
      @(posedge sys_clk); #1;
      penable = 1'b1;
      @(posedge sys_clk); #1;
    endtask

    initial begin
      logic [31:0] a;
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      mem[1] = 32'h1234_5678;
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      chk_all_zero("reset");
      @(posedge sys_clk); #1;
      rst = 1'b0;

      // penable without a SETUP must not start anything
      penable = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1 penable = 1'b0;

      xfer(1'b1, 32'h0000_0000, 32'hA5A5_5A5A);
      xfer(1'b0, 32'h0000_0004, 32'h0);
      xfer(1'b1, 32'h0000_0030, 32'hDEAD_BEEF);
      xfer(1'b1, 32'h0000_0002, 32'hCAFE_F00D);
      xfer(1'b0, 32'h0000_0031, 32'h0);
      // back-to-back write then read
      xfer(1'b1, 32'h0000_000C, 32'h0BAD_CAFE);
      xfer(1'b0, 32'h0000_0010, 32'h0);
      xfer(1'b0, 32'h0000_002C, 32'h0);

      if (WS > 0) begin
        start_to_wait(32'h0000_0008);
        psel = 1'b0; penable = 1'b0;
        repeat (WS + 3) @(posedge sys_clk);
        #1;
        xfer(1'b1, 32'h0000_0014, 32'h5555_AAAA);

        start_to_wait(32'h0000_0000);
        rst = 1'b1;
        @(posedge sys_clk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge sys_clk);
        chk_all_zero("midrst");
        @(posedge sys_clk); #1;
        xfer(1'b0, 32'h0000_0008, 32'h0);
      end

      for (int i = 0; i < 25; i++) begin
        case ($urandom_range(0, 9))
          0: a = {26'd0, 4'($urandom_range(0, 11)), 2'($urandom_range(1, 3))};
          1: a = 32'h30 + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
          2: a = $urandom;
          default: a = {26'd0, 4'($urandom_range(0, 11)), 2'b00};
        endcase
        xfer(1'($urandom_range(0, 1)), a, $urandom);
        repeat ($urandom_range(0, 2)) @(posedge sys_clk);
        #1;
      end

      repeat (5) @(posedge sys_clk);
      check($sformatf("lane%0d rsp_q drained", g), rsp_q.size(), 32'd0);
      check($sformatf("lane%0d wr_q drained", g), wr_q.size(), 32'd0);
      check($sformatf("lane%0d rd_q drained", g), rd_q.size(), 32'd0);
      done_l = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(gen_lane[0].done_l && gen_lane[1].done_l && gen_lane[2].done_l) && n < 20000) begin
      @(posedge sys_clk);
      n++;
    end
    if (!(gen_lane[0].done_l && gen_lane[1].done_l && gen_lane[2].done_l))
      fail_evt("global timeout waiting for lanes");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_apb_slave.md
TIMER_APB_SLAVE -- requirements
Module: timer_apb_slave

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1; extra ACCESS cycles before pready (0..15).
REQ-002 SHALL have parameter ADDR_LAST, default 32'h0000_002C; highest valid word address.
REQ-003 SHALL have port sys_clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst  in  1  synchronous reset, active-high.
REQ-005 SHALL have port tim_psel  in  1  APB select.
REQ-006 SHALL have port tim_penable  in  1  APB access phase.
REQ-007 SHALL have port tim_pwrite  in  1  1 = write, 0 = read.
REQ-008 SHALL have port tim_paddr  in  32  byte address.
REQ-009 SHALL have port tim_pwdata  in  32  write data.
REQ-010 SHALL have port tim_prdata  out  32  read data, registered.
REQ-011 SHALL have port tim_pready  out  1  transfer complete, registered.
REQ-012 SHALL have port tim_pslverr  out  1  error, valid only with tim_pready.
REQ-013 SHALL have port reg_wr_en  out  1  one-cycle register write strobe.
REQ-014 SHALL have port reg_rd_en  out  1  one-cycle register read strobe.
REQ-015 SHALL have port reg_addr  out  10  word address (tim_paddr[11:2]), held for whole transfer.
REQ-016 SHALL have port reg_wdata  out  32  write data to register file.
REQ-017 SHALL have port reg_rdata  in  32  register file read data, valid the cycle after reg_rd_en.

Function
REQ-018 SHALL implement FSM IDLE, ACCESS, WAIT, DONE.
REQ-019 IDLE->ACCESS SHALL occur when tim_psel=1 and tim_penable=0 (SETUP); reg_addr and pwrite are latched on that edge.
REQ-020 Legal address SHALL be tim_paddr[1:0]=0 and tim_paddr<=ADDR_LAST; otherwise the transfer is an error.
REQ-021 In ACCESS, a legal read SHALL pulse reg_rd_en for exactly one cycle; errored transfers SHALL never assert reg_rd_en or reg_wr_en.
REQ-022 ACCESS->WAIT SHALL load a counter with WAIT_STATES; WAIT decrements each cycle and exits to DONE at 0 (WAIT_STATES=0: ACCESS->DONE directly).
REQ-023 Read data SHALL be captured from reg_rdata into tim_prdata on the cycle after reg_rd_en and held until the next read capture.
REQ-024 In DONE, tim_pready SHALL be 1 for exactly one cycle; tim_pslverr=1 in that cycle iff the transfer errored; on an errored read tim_prdata SHALL be 0.
REQ-025 A legal write SHALL pulse reg_wr_en in the DONE cycle, with reg_wdata = tim_pwdata sampled that cycle.
REQ-026 Latency, SETUP edge to tim_pready high = 2 + WAIT_STATES cycles.
REQ-027 DONE->IDLE SHALL be unconditional; a new SETUP in the following cycle SHALL be accepted (back-to-back).
REQ-028 If tim_psel drops in ACCESS or WAIT, the FSM SHALL abort to IDLE without pready, strobes or pslverr.
REQ-029 tim_penable=1 while in IDLE SHALL be ignored (no transfer started).
REQ-030 tim_pready and tim_pslverr SHALL be 0 outside DONE.

Reset
REQ-031 On sys_rst=1 at a clock edge, FSM SHALL go to IDLE, counter 0, tim_prdata 0, tim_pready 0, tim_pslverr 0, reg_wr_en 0, reg_rd_en 0, reg_addr 0, reg_wdata 0.
REQ-032 Reset mid-transfer SHALL discard the transfer with no strobe issued; the first post-reset SETUP SHALL be serviced normally.

Structure
REQ-033 Shared package timer_pkg SHALL hold the FSM state enum, ADDR_LAST default and register word offsets.
REQ-034 Address legality check SHALL be one sub-module, timer_addr_chk (combinational, paddr in, err out).

Verification
REQ-035 Write 0x000 data 0xA5A5_5A5A, WAIT_STATES=1 -> reg_wr_en one cycle with reg_addr 0, reg_wdata 0xA5A5_5A5A; pready 3 cycles after SETUP; pslverr 0.
REQ-036 Read 0x004 with reg_rdata 0x1234_5678 -> reg_rd_en one cycle; tim_prdata 0x1234_5678 when pready=1.
REQ-037 Write 0x030 and write 0x002 -> pready with pslverr 1; reg_wr_en never asserted.
REQ-038 WAIT_STATES=0 and 3, back-to-back write-then-read -> pready at 2 and 5 cycles after each SETUP; second transfer starts the cycle after DONE.
REQ-039 Drop tim_psel in WAIT -> FSM returns to IDLE, no pready, no strobes; next write completes normally.
REQ-040 Assert sys_rst during WAIT of a write -> no reg_wr_en, all outputs 0 next cycle; subsequent read of 0x008 returns reg_rdata.
